wb_regfile: RTL



---
 rtl/wb_regfile_pkg.sv | 44 ++++
 rtl/wb_regfile_rdport.sv | 27 ++
 rtl/wb_regfile.sv | 100 ++++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared types, register IDs and read helper for the write-back register file.
// WB_REGFILE_BYPASS_EN (when defined) enables write-through bypass on the decode read ports.
package wb_regfile_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NREGS  = 15;

    localparam logic [WORD_W-1:0] RESET_VAL = 32'h0000_0000;

    localparam logic [ID_W-1:0] RNONE = 4'hF;
    localparam logic [ID_W-1:0] REAX  = 4'h0;
    localparam logic [ID_W-1:0] RECX  = 4'h1;
    localparam logic [ID_W-1:0] REDX  = 4'h2;
    localparam logic [ID_W-1:0] REBX  = 4'h3;
    localparam logic [ID_W-1:0] RESP  = 4'h4;
    localparam logic [ID_W-1:0] REBP  = 4'h5;
    localparam logic [ID_W-1:0] RESI  = 4'h6;
    localparam logic [ID_W-1:0] REDI  = 4'h7;
    localparam logic [ID_W-1:0] R8    = 4'h8;
    localparam logic [ID_W-1:0] R9    = 4'h9;
    localparam logic [ID_W-1:0] R10   = 4'hA;
    localparam logic [ID_W-1:0] R11   = 4'hB;
    localparam logic [ID_W-1:0] R12   = 4'hC;
    localparam logic [ID_W-1:0] R13   = 4'hD;
    localparam logic [ID_W-1:0] R14   = 4'hE;

    typedef logic [WORD_W-1:0]            word_t;
    typedef logic [ID_W-1:0]              reg_id_t;
    typedef logic [NREGS-1:0][WORD_W-1:0] regarr_t;

    // Plain array read; the "none" ID reads as zero.
    function automatic word_t reg_read(input regarr_t regs, input reg_id_t id);
        word_t val;
        val = '0;
        if (id != RNONE) begin
            val = regs[id];
        end
        return val;
    endfunction

endpackage

// File: rtl/wb_regfile_rdport.sv
// One decode read port: stored value, optionally overridden by the write-back in flight.
module wb_regfile_rdport
    import wb_regfile_pkg::*;
(
    input  logic [ID_W-1:0]   id,
    input  regarr_t           regs,
    input  logic              byp_e_en,
    input  logic [ID_W-1:0]   byp_e_id,
    input  logic [WORD_W-1:0] byp_e_val,
    input  logic              byp_m_en,
    input  logic [ID_W-1:0]   byp_m_id,
    input  logic [WORD_W-1:0] byp_m_val,
    output logic [WORD_W-1:0] val
);

    // M match is applied last so it wins, mirroring the write collision rule.
    always_comb begin
        val = reg_read(regs, id);
        if (byp_e_en && (byp_e_id == id)) begin
            val = byp_e_val;
        end
        if (byp_m_en && (byp_m_id == id)) begin
            val = byp_m_val;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus Y86 register file: dual write ports, two decode reads, debug read.
// WB_REGFILE_BYPASS_EN (when defined) forwards same-cycle writes to d_rvalA/d_rvalB.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] wb_valE,
    input  logic [WORD_W-1:0] wb_valM,
    input  logic [BYTE_W-1:0] wb_dstE,
    input  logic [BYTE_W-1:0] wb_dstM,
    input  logic              wb_stall,
    input  logic [BYTE_W-1:0] d_srcA,
    input  logic [BYTE_W-1:0] d_srcB,
    output logic [WORD_W-1:0] d_rvalA,
    output logic [WORD_W-1:0] d_rvalB,
    input  logic [ID_W-1:0]   dbg_id,
    output logic [WORD_W-1:0] dbg_val,
    output logic [CNT_W-1:0]  wr_cnt
);

    regarr_t          regs_q, regs_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic [ID_W-1:0]  id_e, id_m;
    logic             we_e, we_m, we_e_eff;
    logic [1:0]       n_writes;
    logic [CNT_W:0]   cnt_sum;
    logic             byp_e_en, byp_m_en;

    // Only the low nibble of each ID is architecturally meaningful.
    logic unused_hi;
    assign unused_hi = ^{wb_dstE[7:4], wb_dstM[7:4], d_srcA[7:4], d_srcB[7:4]};

    assign id_e     = wb_dstE[3:0];
    assign id_m     = wb_dstM[3:0];
    assign we_e     = !wb_stall && (id_e != RNONE);
    assign we_m     = !wb_stall && (id_m != RNONE);
    assign we_e_eff = we_e && !(we_m && (id_m == id_e));

    // Next-state: E then M, with the E write dropped on collision; saturating counter.
    always_comb begin
        regs_d = regs_q;
        if (we_e_eff) begin
            regs_d[id_e] = wb_valE;
        end
        if (we_m) begin
            regs_d[id_m] = wb_valM;
        end
        n_writes = 2'(we_e_eff) + 2'(we_m);
        cnt_sum  = (CNT_W+1)'(wr_cnt_q) + (CNT_W+1)'(n_writes);
        wr_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= {NREGS{RESET_VAL}};
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    assign byp_e_en = we_e && !rst;
    assign byp_m_en = we_m && !rst;
`else
    assign byp_e_en = 1'b0;
    assign byp_m_en = 1'b0;
`endif

    wb_regfile_rdport u_rdport_a (
        .id        (d_srcA[3:0]),
        .regs      (regs_q),
        .byp_e_en  (byp_e_en),
        .byp_e_id  (id_e),
        .byp_e_val (wb_valE),
        .byp_m_en  (byp_m_en),
        .byp_m_id  (id_m),
        .byp_m_val (wb_valM),
        .val       (d_rvalA)
    );

    wb_regfile_rdport u_rdport_b (
        .id        (d_srcB[3:0]),
        .regs      (regs_q),
        .byp_e_en  (byp_e_en),
        .byp_e_id  (id_e),
        .byp_e_val (wb_valE),
        .byp_m_en  (byp_m_en),
        .byp_m_id  (id_m),
        .byp_m_val (wb_valM),
        .val       (d_rvalB)
    );

    assign dbg_val = reg_read(regs_q, dbg_id);
    assign wr_cnt  = wr_cnt_q;

endmodule
